// File: rtl/gost89_decrypt.sv
// rtl/gost89_decrypt.sv - iterative GOST 28147-89 ECB block decryptor, one Feistel round per clock
// Optional GOST89_DEC_ENC_EN: adds a mode input sampled at acceptance (1 = encrypt, 0 = decrypt).
`timescale 1ns/1ps
module gost89_decrypt #(
  parameter int ROUNDS = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in_data,
  input  logic [255:0] key,
  input  logic [511:0] sbox,
`ifdef GOST89_DEC_ENC_EN
  input  logic         mode,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_data
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [4:0] LAST = 5'(ROUNDS - 1);

  state_t       state_q, state_d;
  logic [31:0]  n1_q, n1_d;
  logic [31:0]  n2_q, n2_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [63:0]  out_data_q, out_data_d;
  logic         out_valid_q, out_valid_d;
  logic [255:0] key_q;
  logic [511:0] sbox_q;
  logic         mode_q;
  logic         load;

  logic         rev;
  logic [2:0]   kidx;
  logic [31:0]  rk, t, s, rnd;
  logic [3:0]   nib;

  // Key and S-box are captured once per block so the ports are free during RUN.
  always_ff @(posedge clk) begin
    if (load) begin
      key_q  <= key;
      sbox_q <= sbox;
    end
  end

`ifdef GOST89_DEC_ENC_EN
  always_ff @(posedge clk) begin
    if (load) mode_q <= mode;
  end
`else
  assign mode_q = 1'b0;
`endif

  // Forward schedule reverses after round 24, the inverse one after round 8.
  always_comb begin
    rev  = mode_q ? (cnt_q >= 5'd24) : (cnt_q >= 5'd8);
    kidx = rev ? ~cnt_q[2:0] : cnt_q[2:0];
    rk   = key_q[{~kidx, 5'b00000} +: 32];
    t    = n1_q + rk;
    s    = '0;
    nib  = '0;
    for (int r = 0; r < 8; r++) begin
      nib          = t[4*r +: 4];
      s[4*r +: 4]  = sbox_q[{3'(7 - r), ~nib, 2'b00} +: 4];
    end
    rnd  = {s[20:0], s[31:21]} ^ n2_q;
  end

  always_comb begin
    state_d     = state_q;
    n1_d        = n1_q;
    n2_d        = n2_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    load        = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          n1_d    = in_data[63:32];
          n2_d    = in_data[31:0];
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        n1_d  = rnd;
        n2_d  = n1_q;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST) begin
          out_data_d  = {n1_q, rnd};
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      n1_q        <= '0;
      n2_q        <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      n1_q        <= n1_d;
      n2_q        <= n2_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_gost89_decrypt.sv
// tb/tb_gost89_decrypt.sv - scoreboard bench for gost89_decrypt
`timescale 1ns/1ps
module tb_gost89_decrypt;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_data;
  logic [255:0] key;
  logic [511:0] sbox;
  logic         mode_r;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_data;

  int checks   = 0;
  int failures = 0;
  int n_out    = 0;
  int n_exp    = 0;
  logic [63:0] exp_q[$];

  gost89_decrypt #(.ROUNDS(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .key       (key),
    .sbox      (sbox),
`ifdef GOST89_DEC_ENC_EN
    .mode      (mode_r),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] sb_lookup(input logic [511:0] sb, input int r, input int v);
    logic [63:0] row;
    row = sb[511-64*r -: 64];
    return row[63-4*v -: 4];
  endfunction

  // Reference encryptor: forward key order, output {n2, n1} after the last round.
  function automatic logic [63:0] gost_enc(input logic [63:0] p, input logic [255:0] k, input logic [511:0] sb);
    logic [31:0] n1, n2, t, s, tmp, kw;
    int kidx;
    n1 = p[63:32];
    n2 = p[31:0];
    for (int i = 0; i < 32; i++) begin
      kidx = (i < 24) ? (i % 8) : (31 - i);
      kw   = k[255-32*kidx -: 32];
      t    = n1 + kw;
      for (int r = 0; r < 8; r++) s[4*r +: 4] = sb_lookup(sb, r, int'(t[4*r +: 4]));
      tmp  = {s[20:0], s[31:21]} ^ n2;
      n2   = n1;
      n1   = tmp;
    end
    return {n2, n1};
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int j = 0; j < 16; j++) v[32*j +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int j = 0; j < 8; j++) v[32*j +: 32] = $urandom();
    return v;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got %h expected none", out_data);
      end else begin
        chk("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [63:0] d, input logic [255:0] k, input logic [511:0] sb,
                      input logic m, input logic [63:0] exp);
    int n = 0;
    in_data  = d;
    key      = k;
    sbox     = sb;
    mode_r   = m;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(exp);
    n_exp++;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      checks++;
      failures++;
      $display("FAIL valid_timeout: got out_valid=0 expected 1");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [63:0]  p, c, held;
    logic [255:0] k;
    logic [511:0] sb;
    int lat, bad;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode_r = 1'b0;
    in_data = '0; key = '0; sbox = '0;
    #3;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);

    // Zero S-box: every round is a plain swap, so 32 rounds leave the halves exchanged.
    send(64'h0123456789ABCDEF, '0, '0, 1'b0, 64'h89ABCDEF01234567);
    wait_valid(lat);
    chk("latency", 64'(lat), 64'd32);

    // All-F S-box: n1' = ~n2, period 4, so again only the output swap remains.
    send(64'hDEADBEEFCAFEBABE, rand256(), {512{1'b1}}, 1'b0, 64'hCAFEBABEDEADBEEF);

    for (int v = 0; v < 24; v++) begin
      p  = {$urandom(), $urandom()};
      k  = (v == 0) ? '0 : (v == 1) ? {256{1'b1}} : rand256();
      sb = rand512();
      c  = gost_enc(p, k, sb);
      send(c, k, sb, 1'b0, p);
    end
    wait_valid(lat);
    @(posedge clk); #1;

    // Backpressure.
    p = 64'h0011223344556677; k = rand256(); sb = rand512();
    out_ready = 1'b0;
    send(gost_enc(p, k, sb), k, sb, 1'b0, p);
    wait_valid(lat);
    held = out_data;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (!out_valid || out_data !== held || in_ready) bad++;
    end
    chk("bp_stable", 64'(bad), 64'd0);
    chk("bp_held_data", held, p);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 64'(out_valid), 64'd0);
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);

    // Ports change every cycle during RUN.
    p = 64'hFEDCBA9876543210; k = rand256(); sb = rand512();
    send(gost_enc(p, k, sb), k, sb, 1'b0, p);
    for (int i = 0; i < 28; i++) begin
      in_data = {$urandom(), $urandom()}; key = rand256(); sbox = rand512();
      in_valid = 1'(i % 2);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_valid(lat);
    @(posedge clk); #1;

    // Abort mid-RUN at round 17.
    p = 64'h1357924680ACE0BD; k = rand256(); sb = rand512();
    send(gost_enc(p, k, sb), k, sb, 1'b0, p);
    repeat (16) begin @(posedge clk); #1; end
    rst = 1'b1;
    #2;
    chk("abort_run_valid", 64'(out_valid), 64'd0);
    void'(exp_q.pop_back());
    n_exp--;
    @(posedge clk); #1 rst = 1'b0;
    #1;
    chk("abort_run_in_ready", 64'(in_ready), 64'd1);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) bad++;
    end
    chk("abort_no_output", 64'(bad), 64'd0);
    p = 64'h0F1E2D3C4B5A6978; k = rand256(); sb = rand512();
    send(gost_enc(p, k, sb), k, sb, 1'b0, p);
    wait_valid(lat);
    @(posedge clk); #1;

    // Abort while holding in DONE.
    out_ready = 1'b0;
    p = 64'hA5A5A5A55A5A5A5A; k = rand256(); sb = rand512();
    send(gost_enc(p, k, sb), k, sb, 1'b0, p);
    wait_valid(lat);
    rst = 1'b1;
    #2;
    chk("abort_done_valid", 64'(out_valid), 64'd0);
    void'(exp_q.pop_back());
    n_exp--;
    @(posedge clk); #1 rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("abort_done_in_ready", 64'(in_ready), 64'd1);

`ifdef GOST89_DEC_ENC_EN
    for (int v = 0; v < 4; v++) begin
      p  = {$urandom(), $urandom()};
      k  = rand256();
      sb = rand512();
      c  = gost_enc(p, k, sb);
      send(p, k, sb, 1'b1, c);
      send(c, k, sb, 1'b0, p);
    end
`endif

    repeat (40) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("outputs_seen", 64'(n_out), 64'(n_exp));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gost89_decrypt.md
Name: gost89_decrypt

Overview:
Iterative GOST 28147-89 ECB block decryptor. It is the inverse direction of the team's per-round encryption datapath. It takes one 64-bit ciphertext block with its 256-bit key and 512-bit S-box set, runs 32 Feistel rounds at one round per clock using the decryption key order, and returns the 64-bit plaintext. Both sides use valid/ready handshakes. It sits between the bus/DMA front end and the output buffer of the cipher subsystem.

Parameters:
ROUNDS, 32, Feistel round count; values other than 32 are unsupported and exist only for bench shortening.

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  block, key and sbox presented
in_ready  output  1  high only in IDLE
in_data  input  64  ciphertext; n1 = in_data[63:32], n2 = in_data[31:0]
key  input  256  key words k0..k7; kj = key[255-32j -: 32]
sbox  input  512  S-box row r (r = 0 for nibble [3:0] … r = 7 for nibble [31:28]) = sbox[511-64r -: 64]; entry v = row[63-4v -: 4]
out_valid  output  1  plaintext available
out_ready  input  1  consumer accepts
out_data  output  64  plaintext

Behaviour:
- Reset values: in_ready=1 once rst is released (0 while rst is high), out_valid=0, out_data=0, round counter=0, state=IDLE.
- Round function, matching the encrypt path:
  - t = n1 + k (mod 2^32)
  - s = per-nibble S-box substitution of t
  - n1' = rotl11(s) ^ n2
  - n2' = n1
- Decryption key order for round i (0..31): i<8 uses k[i]; i>=8 uses k[7 - (i mod 8)]. The sequence is k0..k7 once, then k7..k0 three times.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid, latch in_data into n1/n2, latch key and sbox into internal registers, clear the counter, go to RUN. Input ports are not sampled again until the next acceptance.
  - RUN: each clock applies one round and increments the counter. After the round with counter = ROUNDS-1, register out_data = {n2', n1'} (final swap undone), set out_valid, go to DONE.
  - DONE: hold out_valid and out_data stable until out_ready. On out_valid & out_ready, clear out_valid, go to IDLE. in_ready rises on the following cycle; there is no same-cycle restart.
- Latency: the acceptance edge is E. out_valid is high after edge E+32. Throughput is one block per at least 34 cycles.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
- Backpressure: with out_ready held low indefinitely, the block stays in DONE and holds its output.
- rst asserted mid-RUN or mid-DONE: the block aborts immediately, out_valid drops, no partial result is emitted, and it returns to IDLE.
- All additions wrap mod 2^32. The rotation is exactly 11 left over 32 bits.

Optional Feature:
GOST89_DEC_ENC_EN
- Defined:
  - An extra input port mode (1 bit) is sampled at acceptance; 1 = encrypt, 0 = decrypt.
  - Encrypt key order: i<24 uses k[i mod 8]; i>=24 uses k[31-i].
  - All other behaviour is identical.
- Undefined: no mode port, and the core only decrypts.

Test Plan:
- All-zero sbox, key=0, in_data=0x0123456789ABCDEF -> out_data=0x89ABCDEF01234567 with out_valid exactly 32 cycles after the acceptance edge.
- Random key/sbox/plaintext encrypted by the golden C model, ciphertext fed in -> out_data equals the original plaintext; repeat for 1000 vectors back-to-back with out_ready=1.
- Backpressure: out_ready=0 for 50 cycles after out_valid -> out_valid and out_data stable, in_ready=0 throughout; first cycle with out_ready=1 completes the transfer, and in_ready=1 on the next cycle.
- Input changes during RUN: change key, sbox and in_data every cycle after acceptance -> result unchanged versus the vector latched at acceptance.
- Assert rst at round 17 -> out_valid never rises for that block; in_ready=1 after release; the next block decrypts correctly.
- With GOST89_DEC_ENC_EN: mode=1 encrypt, then feed the result back with mode=0 -> round-trips to the original 64-bit value for random key/sbox.
